shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Sequencer for the nibble-offset index counter (`param_ShiftDemux`) in the Nibbler nibble-serial datapath. It accepts one shift request at a time, splits the 5-bit shift amount into a nibble offset and a residual bit amount, and steps the index counter to the offset. It then paces the 8-nibble operand stream, steps the index back to zero, and reports completion. It sits in the control unit between execute-stage issue logic and the shift datapath.

## Interface
- `C_N_OFF`, default 8: nibble positions per 32-bit word.
- `C_OFFBITS`, default 3: index width, equal to log2(`C_N_OFF`).
- `clk` input, 1 bit: sole clock.
- `reset` input, 1 bit: synchronous, active-high.
- `req_val` input, 1 bit: shift request valid.
- `req_rdy` output, 1 bit: controller can accept a request.
- `req_shamt` input, 5 bits: shift amount, 0..31.
- `req_dir` input, 1 bit: 1 = left (toward MSB), 0 = right.
- `stall` input, 1 bit: datapath backpressure; freezes the STREAM phase only.
- `demux_en` output, 1 bit: drives the index counter `en`.
- `demux_direction` output, 1 bit: drives the index counter `direction`.
- `bit_shamt` output, 2 bits: residual intra-nibble shift, `req_shamt[1:0]`, held for the whole operation.
- `stream_val` output, 1 bit: the datapath consumes one nibble this cycle.
- `stream_idx` output, `C_OFFBITS` bits: nibble number being streamed, 0..7.
- `stream_last` output, 1 bit: `stream_val` and `stream_idx` == 7.
- `resp_val` output, 1 bit: operation complete.
- `resp_rdy` input, 1 bit: consumer accepts the completion.

## Operation
- FSM states: IDLE, STEP, STREAM, UNWIND, RESP. All state and counters are registered.
- Offset k is `req_shamt[4:2]`, range 0..7. On acceptance, latch k, `req_dir` and `req_shamt[1:0]`.
- **IDLE**
  - `req_rdy` = 1.
  - On `req_val` the request is accepted: go to STEP if k != 0, otherwise go to STREAM.
- **STEP**
  - `demux_en` = 1 and `demux_direction` = latched dir.
  - Step counter loads k and decrements once per cycle.
  - Leave for STREAM after exactly k cycles.
- **STREAM**
  - `stream_val` = !`stall`.
  - `stream_idx` increments on each cycle where `stream_val` is 1.
  - After the cycle where `stream_idx` == 7 and `stream_val` = 1: go to UNWIND if k != 0, otherwise go to RESP.
- **UNWIND**
  - `demux_en` = 1 and `demux_direction` = ~dir, for exactly k cycles.
  - This returns the index counter to 0. The counter wraps mod 8, so left k then right k is exact for every k.
  - Then go to RESP.
- **RESP**
  - `resp_val` = 1, held until `resp_rdy`.
  - On the handshake cycle, go to IDLE.
  - `req_rdy` stays 0 in RESP. There is no accept-on-completion bypass.
- Outside STEP and UNWIND: `demux_en` = 0 and `demux_direction` = 0.
- `stall` is ignored outside STREAM.
- Invariant: in IDLE, the index counter is at 0.

## Timing
- A request is accepted in cycle 0. With no stall, phases occupy:
  - STEP: cycles 1..k.
  - STREAM: cycles k+1..k+8.
  - UNWIND: cycles k+9..2k+8.
  - `resp_val` first high: cycle 2k+9.
- Each stall cycle adds one cycle to STREAM.
- Minimum request-to-request interval is 2k+10 cycles, with `resp_rdy` tied high.
- The index counter updates on the edge following `demux_en`. The index therefore reaches k at the first STREAM cycle.
- `reset` at any edge:
  - State goes to IDLE and all counters clear.
  - Outputs: `req_rdy` = 1. `demux_en`, `demux_direction`, `stream_val`, `stream_last`, `resp_val` = 0. `bit_shamt` and `stream_idx` = 0.
  - The index counter shares the same reset, so the invariant holds after a mid-operation reset.
  - `reset` overrides a `req_val` in the same cycle.

## Structure
- Shared control package holds:
  - State encoding constants `SSC_IDLE` .. `SSC_RESP`, 3 bits.
  - `C_N_OFF` and `C_OFFBITS`.
- The phase counter is shared: STEP and UNWIND count k, STREAM counts 8.
- Natural sub-module: `shift_seq_counter`, a loadable down-counter with enable and a zero flag.
- Parent wiring: instantiates `param_ShiftDemux` beside this block, with `en` and `direction` driven from this block.

## Test plan
- `req_shamt` = 0, left, no stall, `resp_rdy` = 1: no `demux_en`; `stream_val` in cycles 1..8 with `stream_idx` 0..7; `stream_last` in cycle 8; `resp_val` in cycle 9; `bit_shamt` = 0.
- `req_shamt` = 13, left: `bit_shamt` = 1. `demux_en` with direction 1 in cycles 1..3. Index = 3 during STREAM (cycles 4..11). Direction 0 in cycles 12..14. `resp_val` in cycle 15. Index = 0 afterwards.
- `req_shamt` = 31, right: k = 7; index reads 1 (wrap) during STREAM; `resp_val` in cycle 23; index returns to 0.
- `req_shamt` = 4, `stall` high in STREAM cycles 2 and 3: `stream_idx` holds while stalled; `resp_val` is delayed by 2 cycles, to cycle 13.
- `resp_rdy` held low 5 cycles: `resp_val` stays high and `req_rdy` stays 0 throughout, while `req_val` is held high. The next request is accepted the cycle after `resp_rdy` rises.
- `reset` asserted in cycle 2 of STEP with k = 5: next cycle all outputs are at reset values and the index is 0. A fresh `req_shamt` = 8 request then completes with `resp_val` at cycle 13.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared control definitions for the nibble-offset shift sequencer:
// state encodings, word geometry and the shift-amount split helper.
package shift_seq_ctrl_pkg;

    localparam int C_N_OFF   = 8;
    localparam int C_OFFBITS = 3;

    localparam logic [2:0] SSC_IDLE   = 3'd0;
    localparam logic [2:0] SSC_STEP   = 3'd1;
    localparam logic [2:0] SSC_STREAM = 3'd2;
    localparam logic [2:0] SSC_UNWIND = 3'd3;
    localparam logic [2:0] SSC_RESP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = SSC_IDLE,
        ST_STEP   = SSC_STEP,
        ST_STREAM = SSC_STREAM,
        ST_UNWIND = SSC_UNWIND,
        ST_RESP   = SSC_RESP
    } ssc_state_e;

    // Whole-nibble part of a 5-bit shift amount.
    function automatic logic [C_OFFBITS-1:0] nibble_offset(input logic [4:0] shamt);
        return shamt[4:2];
    endfunction

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter with a zero flag; paces every phase of the sequencer.
module shift_seq_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: steps the nibble index to the request offset, paces the
// 8-nibble stream, steps the index back to zero and hands back a completion.
module shift_seq_ctrl #(
    parameter int C_N_OFF   = shift_seq_ctrl_pkg::C_N_OFF,
    parameter int C_OFFBITS = shift_seq_ctrl_pkg::C_OFFBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [4:0]           req_shamt,
    input  logic                 req_dir,
    input  logic                 stall,
    output logic                 demux_en,
    output logic                 demux_direction,
    output logic [1:0]           bit_shamt,
    output logic                 stream_val,
    output logic [C_OFFBITS-1:0] stream_idx,
    output logic                 stream_last,
    output logic                 resp_val,
    input  logic                 resp_rdy
);
    import shift_seq_ctrl_pkg::*;

    localparam logic [C_OFFBITS-1:0] LAST_NIB = C_OFFBITS'(C_N_OFF - 1);
    localparam logic [C_OFFBITS-1:0] ONE      = C_OFFBITS'(1);
    localparam logic [C_OFFBITS-1:0] ZERO     = {C_OFFBITS{1'b0}};

    ssc_state_e             state_r, state_nxt_s;
    logic [C_OFFBITS-1:0]   k_r;
    logic                   dir_r;
    logic [1:0]             bit_r;

    logic [C_OFFBITS-1:0]   req_k_s;
    logic                   accept_s;
    logic                   cnt_load_s, cnt_dec_s, cnt_zero_s;
    logic [C_OFFBITS-1:0]   cnt_val_s, cnt_s;
    logic                   req_rdy_s, demux_en_s, demux_dir_s, stream_val_s, resp_val_s;
    logic [C_OFFBITS-1:0]   stream_idx_s;

    assign req_k_s = nibble_offset(req_shamt);

    shift_seq_counter #(.W(C_OFFBITS)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .dec      (cnt_dec_s),
        .count    (cnt_s),
        .zero     (cnt_zero_s)
    );

    // Next-state, counter control and output decode.
    always_comb begin
        state_nxt_s  = state_r;
        accept_s     = 1'b0;
        cnt_load_s   = 1'b0;
        cnt_val_s    = ZERO;
        cnt_dec_s    = 1'b0;
        req_rdy_s    = 1'b0;
        demux_en_s   = 1'b0;
        demux_dir_s  = 1'b0;
        stream_val_s = 1'b0;
        resp_val_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_rdy_s = 1'b1;
                if (req_val) begin
                    accept_s   = 1'b1;
                    cnt_load_s = 1'b1;
                    if (req_k_s != ZERO) begin
                        state_nxt_s = ST_STEP;
                        cnt_val_s   = req_k_s - ONE;
                    end else begin
                        state_nxt_s = ST_STREAM;
                        cnt_val_s   = LAST_NIB;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                demux_en_s  = 1'b1;
                demux_dir_s = dir_r;
                if (cnt_zero_s) begin
                    state_nxt_s = ST_STREAM;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = LAST_NIB;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_STREAM: begin
                stream_val_s = ~stall;
                if (!stall) begin
                    if (cnt_zero_s) begin
                        if (k_r != ZERO) begin
                            state_nxt_s = ST_UNWIND;
                            cnt_load_s  = 1'b1;
                            cnt_val_s   = k_r - ONE;
                        end else begin
                            state_nxt_s = ST_RESP;
                        end
                    end else begin
                        cnt_dec_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_UNWIND: begin
                demux_en_s  = 1'b1;
                demux_dir_s = ~dir_r;
                if (cnt_zero_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_RESP: begin
                resp_val_s = 1'b1;
                if (resp_rdy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // The stream counter runs down, so the nibble number is its complement.
    always_comb begin
        stream_idx_s = ZERO;
        if (state_r == ST_STREAM) begin
            stream_idx_s = LAST_NIB - cnt_s;
        end else begin
            stream_idx_s = ZERO;
        end
    end

    // State and latched request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            k_r     <= ZERO;
            dir_r   <= 1'b0;
            bit_r   <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                k_r   <= req_k_s;
                dir_r <= req_dir;
                bit_r <= req_shamt[1:0];
            end else begin
                k_r   <= k_r;
                dir_r <= dir_r;
                bit_r <= bit_r;
            end
        end
    end

    assign req_rdy         = req_rdy_s;
    assign demux_en        = demux_en_s;
    assign demux_direction = demux_dir_s;
    assign bit_shamt       = bit_r;
    assign stream_val      = stream_val_s;
    assign stream_idx      = stream_idx_s;
    assign stream_last     = stream_val_s && (stream_idx_s == LAST_NIB);
    assign resp_val        = resp_val_s;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: builds each operation's expected cycle schedule
// from the phase rules and emulates the index counter from demux_en/direction.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, req_val, req_rdy, req_dir, stall;
    logic [4:0] req_shamt;
    logic       demux_en, demux_direction, stream_val, stream_last, resp_val, resp_rdy;
    logic [1:0] bit_shamt;
    logic [2:0] stream_idx;

    int         checks = 0;
    int         errors = 0;
    int         idx_model = 0;
    logic [1:0] bit_exp = 2'b00;
    int         t_op = 0;
    bit         resp_seen = 1'b0;
    int         resp_obs = -1;

    shift_seq_ctrl #(.C_N_OFF(8), .C_OFFBITS(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_shamt       (req_shamt),
        .req_dir         (req_dir),
        .stall           (stall),
        .demux_en        (demux_en),
        .demux_direction (demux_direction),
        .bit_shamt       (bit_shamt),
        .stream_val      (stream_val),
        .stream_idx      (stream_idx),
        .stream_last     (stream_last),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0d got %0d expected %0d", tag, t_op, obs, exp_v);
        end
    endtask

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] rsh();
        return 5'($urandom_range(0, 31));
    endfunction

    // One clock: drive inputs, check outputs at negedge, advance the index model.
    task automatic tick(input bit rv, input logic [4:0] sh, input bit rd, input bit st,
                        input bit rr, input bit rst,
                        input bit e_rdy, input bit e_en, input bit e_dir, input bit e_val,
                        input int e_idx, input bit e_resp, input int e_index);
        req_val = rv; req_shamt = sh; req_dir = rd; stall = st; resp_rdy = rr; reset = rst;
        @(negedge clk);
        if (!rst) begin
            chk("req_rdy",     req_rdy,         e_rdy);
            chk("demux_en",    demux_en,        e_en);
            chk("demux_dir",   demux_direction, e_dir);
            chk("stream_val",  stream_val,      e_val);
            chk("stream_idx",  stream_idx,      e_idx);
            chk("stream_last", stream_last,     e_val && (e_idx == 7));
            chk("resp_val",    resp_val,        e_resp);
            chk("bit_shamt",   bit_shamt,       bit_exp);
            if (e_index >= 0) chk("index", idx_model, e_index);
        end
        if (resp_val === 1'b1 && !resp_seen) begin
            resp_seen = 1'b1;
            resp_obs  = t_op;
        end
        if (rst) begin
            idx_model = 0;
            bit_exp   = 2'b00;
        end else begin
            if (rv && e_rdy) bit_exp = sh[1:0];
            if (demux_en === 1'b1) idx_model = demux_direction ? (idx_model + 1) % 8 : (idx_model + 7) % 8;
        end
        t_op++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        tick(1'b0, rsh(), rbit(), rbit(), rbit(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    // Full operation from acceptance to completion handshake.
    task automatic run_op(input logic [4:0] sh, input bit d, input int stall_nib, input int stall_len,
                          input bit rand_stall, input int rdy_wait, input bit hold_req);
        int k, sidx, nstall, ns;
        k      = int'(sh[4:2]);
        sidx   = d ? k : (8 - k) % 8;
        nstall = 0;
        t_op = 0; resp_seen = 1'b0; resp_obs = -1;
        tick(1'b1, sh, d, rbit(), rbit(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < k; i++)
            tick(rbit(), rsh(), rbit(), rbit(), rbit(), 1'b0,
                 1'b0, 1'b1, d, 1'b0, 0, 1'b0, d ? i : (8 - i) % 8);
        for (int n = 0; n < 8; n++) begin
            ns = (n == stall_nib) ? stall_len : 0;
            if (rand_stall && $urandom_range(0, 3) == 0) ns += int'($urandom_range(1, 2));
            nstall += ns;
            for (int s = 0; s < ns; s++)
                tick(rbit(), rsh(), rbit(), 1'b1, rbit(), 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, n, 1'b0, sidx);
            tick(rbit(), rsh(), rbit(), 1'b0, rbit(), 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b1, n, 1'b0, sidx);
        end
        for (int i = 0; i < k; i++)
            tick(rbit(), rsh(), rbit(), rbit(), rbit(), 1'b0,
                 1'b0, 1'b1, !d, 1'b0, 0, 1'b0, d ? (k - i) : (8 - k + i) % 8);
        for (int w = 0; w < rdy_wait; w++)
            tick(hold_req ? 1'b1 : rbit(), rsh(), rbit(), rbit(), 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
        tick(hold_req ? 1'b1 : rbit(), rsh(), rbit(), rbit(), 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
        chk("resp_cycle", resp_obs, 2 * k + 9 + nstall);
    endtask

    initial begin
        req_val = 1'b0; req_shamt = 5'd0; req_dir = 1'b0; stall = 1'b0; resp_rdy = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        tick(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
        tick(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
        idle_cycle();

        run_op(5'd0,  1'b1, -1, 0, 1'b0, 0, 1'b0);
        idle_cycle();
        run_op(5'd13, 1'b1, -1, 0, 1'b0, 0, 1'b0);
        idle_cycle();
        run_op(5'd31, 1'b0, -1, 0, 1'b0, 0, 1'b0);
        idle_cycle();
        run_op(5'd4,  1'b1,  1, 2, 1'b0, 0, 1'b0);
        run_op(5'd22, 1'b0, -1, 0, 1'b0, 5, 1'b1);
        run_op(5'd7,  1'b1, -1, 0, 1'b0, 0, 1'b0);

        // Reset mid-STEP with k = 5, then reset overriding a request in IDLE.
        t_op = 0;
        tick(1'b1, 5'd21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        tick(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        tick(1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
        tick(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        tick(1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
        tick(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        run_op(5'd8, 1'b1, -1, 0, 1'b0, 0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_cycle();
            run_op(rsh(), rbit(), -1, 0, 1'b1, int'($urandom_range(0, 3)), rbit());
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
